// File: rtl/duty_fade_pkg.sv
// ============================================================================
// Module   : duty_fade_pkg
// Purpose  : Shared state encoding and default widths for the duty_fade block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package duty_fade_pkg;

    localparam int c_DUTY_W = 8;
    localparam int c_STEP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_HOLD = 2'd2,
        ST_DOWN = 2'd3
    } fade_state_t;

endpackage

`default_nettype wire

// File: rtl/duty_fade_if.sv
// ============================================================================
// Module   : duty_fade_if
// Purpose  : Control/status bundle between a sequencer master and duty_fade.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface duty_fade_if
    import duty_fade_pkg::*;
#(
    parameter int R      = c_DUTY_W,
    parameter int STEP_W = c_STEP_W
);
    logic              start;
    logic              stop;
    logic              loop;
    logic [STEP_W-1:0] step_div;
    logic [STEP_W-1:0] hold_ticks;
    logic [R-1:0]      duty_max;
    logic [R-1:0]      duty;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, loop, step_div, hold_ticks, duty_max,
        input  duty, busy, done
    );

    modport slave (
        input  start, stop, loop, step_div, hold_ticks, duty_max,
        output duty, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/duty_fade_tick_gen.sv
// ============================================================================
// Module   : fade_tick_gen
// Purpose  : Step prescaler; emits one tick every step_div+1 enabled clocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fade_tick_gen #(
    parameter int STEP_W = 16
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              i_enable,
    input  wire logic              i_run,
    input  wire logic              i_clear,
    input  wire logic [STEP_W-1:0] i_step_div,
    output logic                   o_tick
);

    logic [STEP_W-1:0] r_cnt;

    // step_div is compared live so a new value applies at the next compare
    assign o_tick = i_run && (r_cnt == i_step_div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            if (i_clear || !i_run || o_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/duty_fade.sv
// ============================================================================
// Module   : duty_fade
// Purpose  : Linear up/hold/down duty sequencer feeding a PWM stage.
// Options  : DUTY_FADE_GAMMA_EN - registered square-law output shaping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module duty_fade
    import duty_fade_pkg::*;
#(
    parameter int R      = c_DUTY_W,
    parameter int STEP_W = c_STEP_W
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    input  wire logic   enable,
    duty_fade_if.slave  bus
);

    fade_state_t       r_state;
    fade_state_t       w_state_nxt;
    logic [R-1:0]      r_lin;
    logic [R-1:0]      w_lin_nxt;
    logic [R-1:0]      r_max;
    logic [R-1:0]      w_max_nxt;
    logic [STEP_W-1:0] r_hold;
    logic [STEP_W-1:0] w_hold_nxt;
    logic              r_stopped;
    logic              w_stopped_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_tick;
    logic              w_busy;
    logic              w_state_chg;
    logic [R-1:0]      w_lin_inc;
    logic [R-1:0]      w_lin_dec;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_state_chg = (w_state_nxt != r_state);
    assign w_lin_inc   = r_lin + 1'b1;
    assign w_lin_dec   = r_lin - 1'b1;

    fade_tick_gen #(
        .STEP_W (STEP_W)
    ) u_tick_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_enable   (enable),
        .i_run      (w_busy),
        .i_clear    (w_state_chg),
        .i_step_div (bus.step_div),
        .o_tick     (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_lin     <= '0;
            r_max     <= '0;
            r_hold    <= '0;
            r_stopped <= 1'b0;
            r_done    <= 1'b0;
        end else if (enable) begin
            r_state   <= w_state_nxt;
            r_lin     <= w_lin_nxt;
            r_max     <= w_max_nxt;
            r_hold    <= w_hold_nxt;
            r_stopped <= w_stopped_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lin_nxt     = r_lin;
        w_max_nxt     = r_max;
        w_hold_nxt    = r_hold;
        w_stopped_nxt = r_stopped;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_state_nxt   = ST_UP;
                    w_max_nxt     = bus.duty_max;
                    w_lin_nxt     = '0;
                    w_stopped_nxt = 1'b0;
                end
            end
            ST_UP: begin
                // stop wins over a coincident tick: duty holds on that edge
                if (bus.stop) begin
                    w_state_nxt   = ST_DOWN;
                    w_stopped_nxt = 1'b1;
                end else if (w_tick) begin
                    if (r_max == '0) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_lin_nxt = w_lin_inc;
                        if (w_lin_inc == r_max) begin
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (bus.stop) begin
                    w_state_nxt   = ST_DOWN;
                    w_stopped_nxt = 1'b1;
                    w_hold_nxt    = '0;
                end else if (w_tick) begin
                    if (r_hold == bus.hold_ticks) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_DOWN;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
            end
            ST_DOWN: begin
                if (w_tick) begin
                    // covers both the normal last step and a zero-peak entry
                    if ((r_lin == '0) || (w_lin_dec == '0)) begin
                        w_lin_nxt = '0;
                        if (bus.loop && !r_stopped) begin
                            w_state_nxt = ST_UP;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_lin_nxt = w_lin_dec;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;

`ifdef DUTY_FADE_GAMMA_EN
    logic [2*R-1:0] w_lin_ext;
    logic [R-1:0]   w_sq_hi;
    logic [R-1:0]   w_sq_lo_unused;
    logic [R-1:0]   r_gamma;

    assign w_lin_ext                 = {{R{1'b0}}, r_lin};
    assign {w_sq_hi, w_sq_lo_unused} = w_lin_ext * w_lin_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gamma <= '0;
        end else if (enable) begin
            r_gamma <= w_sq_hi;
        end
    end

    assign bus.duty = r_gamma;
`else
    assign bus.duty = r_lin;
`endif

endmodule

`default_nettype wire

// File: tb/tb_duty_fade.sv
// ============================================================================
// Module   : tb_duty_fade
// Purpose  : Randomised self-checking bench for duty_fade against a
//            closed-form model of the fade envelope.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_duty_fade;

    localparam int R = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    duty_fade_if #(.R(R), .STEP_W(16)) bus ();

    duty_fade #(.R(R), .STEP_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Linear envelope after e enabled edges from the start edge: ticks land
    // every p edges, tick n gives min(n, peak, total_ticks - n).
    function automatic int lin_at(int e, int m, int h, int p, bit lp);
        int t, n, r;
        t = (m == 0) ? h + 3 : 2 * m + h + 1;
        if (e < 0) return 0;
        if (lp) e = e % (t * p);
        else if (e >= t * p) return 0;
        if (m == 0) return 0;
        n = e / p;
        r = n;
        if (m < r) r = m;
        if (t - n < r) r = t - n;
        return r;
    endfunction

    // se >= 0: stop sampled at the edge ending enabled cycle se
    function automatic int lin_m(int e, int m, int h, int p, bit lp, int se);
        int d, k;
        if (se >= 0 && e > se) begin
            d = lin_at(se, m, h, p, lp);
            k = (e - se - 1) / p;
            return (k >= d) ? 0 : d - k;
        end
        return lin_at(e, m, h, p, lp);
    endfunction

    // enabled-edge index at which the sequence is back in IDLE (-1: never)
    function automatic int end_m(int m, int h, int p, bit lp, int se);
        int d;
        if (se >= 0) begin
            d = lin_at(se, m, h, p, lp);
            return se + 1 + ((d == 0) ? 1 : d) * p;
        end
        if (lp) return -1;
        return ((m == 0) ? h + 3 : 2 * m + h + 1) * p;
    endfunction

    function automatic void expect_at(input int e, input int m, input int h, input int p,
                                      input bit lp, input int se,
                                      output int d, output logic b, output logic dn);
        int en;
`ifdef DUTY_FADE_GAMMA_EN
        int pl;
`endif
        en = end_m(m, h, p, lp, se);
        if (en < 0) begin
            b  = 1'b1;
            dn = 1'b0;
        end else begin
            b  = (e < en);
            dn = (e == en);
        end
`ifdef DUTY_FADE_GAMMA_EN
        pl = lin_m(e - 1, m, h, p, lp, se);
        d  = (pl * pl) >> R;
`else
        d  = lin_m(e, m, h, p, lp, se);
`endif
    endfunction

    task automatic begin_seq(int m, int h, int sd, bit lp);
        bus.duty_max   = m[7:0];
        bus.hold_ticks = h[15:0];
        bus.step_div   = sd[15:0];
        bus.loop       = lp;
        bus.stop       = 1'b0;
        enable         = 1'b1;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.stop = 1'b0; bus.loop = 1'b1;
        bus.step_div = '0; bus.hold_ticks = '0; bus.duty_max = 8'd9;
        enable = 1'b1;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.duty !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset: duty=%0d busy=%b done=%b, expected 0 0 0",
                         bus.duty, bus.busy, bus.done);
            end
        end
        bus.start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: busy=%b, expected 0", bus.busy);
        end
    endtask

    task automatic test_one_shot();
        int m, h, sd, p, lim, ed;
        logic eb, edn;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin m = 4;   h = 1; sd = 0; end
                1: begin m = 0;   h = 2; sd = 1; end
                2: begin m = 255; h = 0; sd = 0; end
                default: begin
                    m  = $urandom_range(12, 1);
                    h  = $urandom_range(3, 0);
                    sd = $urandom_range(3, 0);
                end
            endcase
            p = sd + 1;
            begin_seq(m, h, sd, 1'b0);
            lim = end_m(m, h, p, 1'b0, -1) + 2;
            for (int e = 0; e <= lim; e++) begin
                expect_at(e, m, h, p, 1'b0, -1, ed, eb, edn);
                n_vec++;
                if (bus.duty !== 8'(ed) || bus.busy !== eb || bus.done !== edn) begin
                    n_bad++;
                    $display("FAIL one_shot m=%0d h=%0d sd=%0d e=%0d: duty=%0d busy=%b done=%b, expected %0d %b %b",
                             m, h, sd, e, bus.duty, bus.busy, bus.done, ed, eb, edn);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_prescale_enable();
        int m, h, sd, p, lim, ed, e, cyc, gap;
        logic eb, edn, en;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                m = 2; h = 0; sd = 3;
            end else begin
                m  = $urandom_range(6, 1);
                h  = $urandom_range(2, 0);
                sd = $urandom_range(3, 0);
            end
            p = sd + 1;
            begin_seq(m, h, sd, 1'b0);
            lim = end_m(m, h, p, 1'b0, -1) + 2;
            e = 0; cyc = 0; gap = 0;
            while (e <= lim && cyc < 2000) begin
                expect_at(e, m, h, p, 1'b0, -1, ed, eb, edn);
                n_vec++;
                if (bus.duty !== 8'(ed) || bus.busy !== eb || bus.done !== edn) begin
                    n_bad++;
                    $display("FAIL prescale_enable sd=%0d e=%0d: duty=%0d busy=%b done=%b, expected %0d %b %b",
                             sd, e, bus.duty, bus.busy, bus.done, ed, eb, edn);
                end
                if (i == 0 && e == 5 && cyc == 5) gap = 5;
                if (gap > 0) begin
                    en = 1'b0;
                    gap--;
                end else begin
                    en = (i == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
                end
                enable = en;
                @(negedge clk);
                if (en) e++;
                cyc++;
            end
            enable = 1'b1;
            if (cyc >= 2000) begin
                n_bad++;
                $display("FAIL prescale_enable timeout: reached e=%0d, required %0d", e, lim);
            end
        end
    endtask

    task automatic test_stop();
        int m, h, sd, p, se, lim, ed;
        logic eb, edn;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                m = 10; h = 2; sd = 0; se = 6;
            end else begin
                m  = $urandom_range(12, 2);
                h  = $urandom_range(3, 0);
                sd = $urandom_range(2, 0);
                se = $urandom_range((m + h + 1) * (sd + 1) - 1, 0);
            end
            p = sd + 1;
            begin_seq(m, h, sd, 1'b1);
            lim = end_m(m, h, p, 1'b1, se) + 2;
            for (int e = 0; e <= lim; e++) begin
                expect_at(e, m, h, p, 1'b1, se, ed, eb, edn);
                n_vec++;
                if (bus.duty !== 8'(ed) || bus.busy !== eb || bus.done !== edn) begin
                    n_bad++;
                    $display("FAIL stop m=%0d se=%0d e=%0d: duty=%0d busy=%b done=%b, expected %0d %b %b",
                             m, se, e, bus.duty, bus.busy, bus.done, ed, eb, edn);
                end
                bus.stop = (e == se);
                @(negedge clk);
            end
            bus.stop = 1'b0;
            bus.loop = 1'b0;
        end
    endtask

    task automatic test_collision();
        bus.duty_max = 8'd5;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.busy !== 1'b0 || bus.duty !== 8'd0 || bus.done !== 1'b0) begin
                n_bad++;
                $display("FAIL collision: busy=%b duty=%0d done=%b, expected 0 0 0",
                         bus.busy, bus.duty, bus.done);
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic test_loop_reset();
        int m, h, sd, p, t, er, ed;
        logic eb, edn;
        m  = 3;
        h  = $urandom_range(2, 0);
        sd = $urandom_range(1, 0);
        p  = sd + 1;
        t  = 2 * m + h + 1;
        er = 2 * t * p + (m + h + 2) * p;
        begin_seq(m, h, sd, 1'b1);
        for (int e = 0; e < er; e++) begin
            expect_at(e, m, h, p, 1'b1, -1, ed, eb, edn);
            n_vec++;
            if (bus.duty !== 8'(ed) || bus.busy !== eb || bus.done !== edn) begin
                n_bad++;
                $display("FAIL loop h=%0d sd=%0d e=%0d: duty=%0d busy=%b done=%b, expected %0d %b %b",
                         h, sd, e, bus.duty, bus.busy, bus.done, ed, eb, edn);
            end
            @(negedge clk);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (bus.duty !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: duty=%0d busy=%b done=%b, expected 0 0 0",
                     bus.duty, bus.busy, bus.done);
        end
        bus.loop = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.duty !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset: duty=%0d busy=%b done=%b, expected 0 0 0",
                         bus.duty, bus.busy, bus.done);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_one_shot();
        test_prescale_enable();
        test_stop();
        test_collision();
        test_loop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/duty_fade.md
Name: duty_fade

Overview:
- Duty-cycle sequencer feeding the PWM stage's `duty` input; the two blocks share clock and reset.
- On `start`, ramps duty linearly from 0 up to a programmable peak, holds it, then ramps back down to 0.
- Runs one-shot or looping; used for LED breathing and motor soft-start/soft-stop.
- Rate is set by a programmable prescaler that produces one "step tick" every `step_div`+1 enabled clocks.

Parameters:
- R, 8, duty width; must match the downstream PWM resolution.
- STEP_W, 16, width of the step prescaler and the hold counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  reset; asynchronous, active-low.
- enable  in  1  clock enable; low freezes all state, counters and outputs.
- start  in  1  begin sequence; sampled only in IDLE.
- stop  in  1  graceful abort: skip to the ramp-down.
- loop  in  1  1 = restart UP after DOWN completes; 0 = one-shot. Sampled at each DOWN-to-0 event.
- step_div  in  STEP_W  clocks per step minus 1.
- hold_ticks  in  STEP_W  peak hold length minus 1, in ticks.
- duty_max  in  R  peak duty; latched at start.
- duty  out  R  duty value to the PWM stage.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a one-shot sequence returns to IDLE.

Behaviour:
- Reset values: state = IDLE, duty = 0, busy = 0, done = 0, prescaler = 0, hold counter = 0, latched max = 0. Reset mid-sequence aborts immediately, with no ramp-down.
- States: IDLE, UP, HOLD, DOWN. State is registered; `busy` is decoded from state.
- Gating: nothing changes while enable = 0, including `done`, which stays held.
- Prescaler:
  - Counts only in UP, HOLD and DOWN.
  - tick = (prescaler == step_div); on a tick the prescaler clears to 0.
  - Cleared on every state change.
  - step_div = 0 gives a tick on every enabled cycle.
- IDLE:
  - start & ~stop: latch duty_max, set duty = 0, go to UP.
  - start & stop together: stay in IDLE.
- UP:
  - On tick: duty <= duty + 1.
  - If duty + 1 == max_latched, go to HOLD.
  - If max_latched == 0, go to HOLD on the first tick with duty staying 0 (no wrap).
- HOLD:
  - Duty is constant.
  - The hold counter increments on each tick.
  - On the tick where hold counter == hold_ticks, clear the counter and go to DOWN.
  - HOLD therefore lasts hold_ticks + 1 ticks.
- DOWN:
  - On tick: duty <= duty − 1.
  - When duty − 1 == 0: go to UP if loop = 1; otherwise go to IDLE and assert done for that one cycle.
  - DOWN entered with duty == 0 (the max = 0 case) finishes on its first tick with no underflow.
- stop:
  - In UP or HOLD: go to DOWN on the next enabled edge; duty is unchanged on that edge.
  - In DOWN: ignored.
  - Also forces loop off for the remainder of the current sequence.
- Duty arithmetic is R-bit and never wraps; duty ≤ max_latched ≤ 2^R − 1.
- start while busy: ignored.
- step_div or hold_ticks changed mid-sequence: takes effect at the next compare (not latched).
- Latency from start to first duty increment: step_div + 2 cycles. Duty is registered.

Optional Feature:
- Macro: DUTY_FADE_GAMMA_EN.
- When defined:
  - duty = (lin × lin) >> R, registered, where lin is the internal linear ramp value.
  - Adds one cycle of latency relative to state; reset value 0.
  - Peak 255 (R = 8) outputs 254.
  - State and `done` timing are unchanged.
- When undefined: duty equals the linear register directly; no multiplier is instantiated.

Decomposition:
- Package duty_fade_pkg:
  - state enum typedef (IDLE/UP/HOLD/DOWN, 2-bit);
  - default R and STEP_W constants.
- Sub-module fade_tick_gen: prescaler with enable, clear and step_div inputs, and a tick output.
- Top-level duty_fade holds the FSM, duty register, hold counter and optional gamma stage.

Test Plan:
- Basic one-shot:
  - Stimulus: R = 8, step_div = 0, duty_max = 4, hold_ticks = 1, loop = 0, one start pulse.
  - Response: duty per cycle 0,1,2,3,4,4,4,3,2,1,0; done high exactly in the cycle duty returns to 0; busy then low.
- Prescale and enable:
  - Stimulus: step_div = 3, duty_max = 2; enable low for 5 cycles mid-UP.
  - Response: duty steps every 4 enabled cycles; duty, prescaler and state frozen during the 5-cycle gap.
- Stop mid-ramp:
  - Stimulus: duty_max = 10, step_div = 0; stop asserted when duty = 6.
  - Response: duty 6, then 5,4,3,2,1,0; done pulses; HOLD never entered.
- Zero peak and start/stop collision:
  - Stimulus: duty_max = 0; separately, start & stop high in IDLE.
  - Response: duty stays 0 through UP/HOLD/DOWN and done pulses; the collision leaves busy = 0.
- Loop and async reset:
  - Stimulus: loop = 1, duty_max = 3; reset_n pulsed low mid-DOWN.
  - Response: before reset, duty sequence repeats with no done. After reset, duty = 0, busy = 0 and done = 0 immediately, with no clock edge required.
- Gamma (DUTY_FADE_GAMMA_EN defined):
  - Stimulus: duty_max = 255, step_div = 0.
  - Response: output 0 at lin = 0, 64 at lin = 128, 254 at lin = 255; output lags the linear ramp by one cycle.
